// File: rtl/seg_display_arbiter.sv
// Purpose: shares one 4-digit seven-segment display between two requesters with round-robin ties and a minimum hold.
// Latency: req -> gnt and data -> disp_data are 1 cycle, and all outputs are registered.
// Backpressure: none. Requesters hold req as a level until they are granted, and losers simply wait.
module seg_display_arbiter #(
   parameter int unsigned HOLD_CYCLES  = 25_000_000,
   parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic [15:0] data0,
   input  logic        req1,
   input  logic [15:0] data1,
   output logic        gnt0,
   output logic        gnt1,
   output logic [15:0] disp_data,
   output logic        hold_done
);

   localparam int unsigned     CW       = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0]   HOLD_MAX = CW'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            last_q, last_d;          // index of the most recent owner; 1 lets requester 0 win the first tie
   logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
   logic            hold_done_q, hold_done_d;
   logic            gnt0_q, gnt0_d;
   logic            gnt1_q, gnt1_d;
   logic [15:0]     disp_q, disp_d;
   logic            hold_reached;
   logic            staying;

   assign hold_reached = (hold_cnt_q == HOLD_MAX);

   // Ownership decision: release beats hold, and preemption only after the hold has elapsed
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req0 && req1)  state_d = last_q ? ST_OWN0 : ST_OWN1;
            else if (req0)     state_d = ST_OWN0;
            else if (req1)     state_d = ST_OWN1;
         end
         ST_OWN0: begin
            if (!req0)                      state_d = req1 ? ST_OWN1 : ST_IDLE;
            else if (req1 && hold_reached)  state_d = ST_OWN1;
         end
         ST_OWN1: begin
            if (!req1)                      state_d = req0 ? ST_OWN0 : ST_IDLE;
            else if (req0 && hold_reached)  state_d = ST_OWN0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered outputs follow the next owner, so grant and its data land on the same edge
   always_comb begin
      gnt0_d      = (state_d == ST_OWN0);
      gnt1_d      = (state_d == ST_OWN1);
      last_d      = last_q;
      disp_d      = IDLE_PATTERN;
      hold_cnt_d  = '0;
      staying     = (state_d != ST_IDLE) && (state_d == state_q);
      case (state_d)
         ST_OWN0: begin
            disp_d = data0;
            last_d = 1'b0;
         end
         ST_OWN1: begin
            disp_d = data1;
            last_d = 1'b1;
         end
         default: ;
      endcase
      // A fresh grant or switch restarts the hold; staying counts up and saturates
      if (staying) begin
         hold_cnt_d = hold_reached ? hold_cnt_q : hold_cnt_q + CW'(1);
      end
      hold_done_d = (hold_cnt_d == HOLD_MAX);
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         hold_cnt_q  <= '0;
         hold_done_q <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         disp_q      <= IDLE_PATTERN;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         hold_cnt_q  <= hold_cnt_d;
         hold_done_q <= hold_done_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         disp_q      <= disp_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign disp_data = disp_q;
   assign hold_done = hold_done_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter with HOLD_CYCLES=4 and an idle word of zero.
// A reference model tracks the owner and the edges elapsed since that owner's grant.
// Directed scenarios run first, followed by a randomized contention phase.
module tb_seg_display_arbiter;

   localparam int HOLD = 4;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [15:0] data0, data1;
   logic        gnt0, gnt1, hold_done;
   logic [15:0] disp_data;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_owner;   // -1 idle, 0 or 1
   int          m_since;   // edges elapsed since the current owner was granted
   int          m_last;    // most recent owner
   logic [15:0] m_disp;

   seg_display_arbiter #(.HOLD_CYCLES(HOLD), .IDLE_PATTERN(16'h0000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .data0     (data0),
      .req1      (req1),
      .data1     (data1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .disp_data (disp_data),
      .hold_done (hold_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void m_reset();
      m_owner = -1;
      m_since = 0;
      m_last  = 1;
      m_disp  = 16'h0000;
   endfunction

   function automatic void m_step();
      int  nxt;
      bit  mine, other, held;
      held = (m_owner >= 0) && (m_since >= HOLD);
      if (m_owner < 0) begin
         if (req0 && req1)  nxt = (m_last == 0) ? 1 : 0;
         else if (req0)     nxt = 0;
         else if (req1)     nxt = 1;
         else               nxt = -1;
      end else begin
         mine  = (m_owner == 0) ? req0 : req1;
         other = (m_owner == 0) ? req1 : req0;
         if (!mine)                nxt = other ? 1 - m_owner : -1;
         else if (other && held)   nxt = 1 - m_owner;
         else                      nxt = m_owner;
      end
      if (nxt < 0) begin
         m_since = 0;
      end else if (nxt != m_owner) begin
         m_since = 0;
         m_last  = nxt;
      end else begin
         m_since = m_since + 1;
      end
      m_owner = nxt;
      m_disp  = (nxt == 0) ? data0 : (nxt == 1) ? data1 : 16'h0000;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".gnt0"},  {15'd0, gnt0},      {15'd0, m_owner == 0});
      chk({tag, ".gnt1"},  {15'd0, gnt1},      {15'd0, m_owner == 1});
      chk({tag, ".disp"},  disp_data,          m_disp);
      chk({tag, ".hdone"}, {15'd0, hold_done}, {15'd0, (m_owner >= 0) && (m_since >= HOLD)});
      chk({tag, ".excl"},  {15'd0, gnt0 & gnt1}, 16'd0);
   endtask

   // one clock edge: advance the model from the inputs present at the edge, then sample after it
   task automatic tick(input string tag);
      @(posedge clk);
      if (rst_n) m_step();
      else       m_reset();
      #1;
      check_all(tag);
   endtask

   initial begin
      // 1. reset with random requests, then release idle
      rst_n = 1'b0;
      req0  = 1'($urandom);
      req1  = 1'($urandom);
      data0 = 16'($urandom);
      data1 = 16'($urandom);
      m_reset();
      #1;
      check_all("rst0");
      chk("rst0.disp_const", disp_data, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         req0 = 1'($urandom);
         req1 = 1'($urandom);
         tick("rst_hold");
      end
      rst_n = 1'b1;
      req0  = 1'b0;
      req1  = 1'b0;
      for (int i = 0; i < 10; i++) tick("idle");

      // 2. single requester, live data tracking
      req1  = 1'b1;
      data1 = 16'h1234;
      tick("single.grant");
      chk("single.gnt1_const", {15'd0, gnt1}, 16'd1);
      chk("single.disp_const", disp_data, 16'h1234);
      data1 = 16'hABCD;
      tick("single.track");
      chk("single.track_const", disp_data, 16'hABCD);
      data0 = 16'h5555;
      tick("single.other_data");
      req1 = 1'b0;
      tick("single.release");

      // 3. tie after reset: requester 0 first, then alternate every HOLD+1 edges
      rst_n = 1'b0;
      m_reset();
      #1;
      check_all("tie.rst");
      @(negedge clk);
      rst_n = 1'b1;
      req0  = 1'b1;
      req1  = 1'b1;
      data0 = 16'h0A0A;
      data1 = 16'h0B0B;
      tick("tie.first");
      chk("tie.gnt0_first", {15'd0, gnt0}, 16'd1);
      for (int i = 0; i < HOLD; i++) tick("tie.hold");
      chk("tie.hdone_const", {15'd0, hold_done}, 16'd1);
      tick("tie.switch");
      chk("tie.gnt1_after", {15'd0, gnt1}, 16'd1);
      for (int i = 0; i < 3 * (HOLD + 1); i++) tick("tie.alt");

      // 4. early release hands over before the hold elapses
      req0 = 1'b0;
      req1 = 1'b0;
      tick("early.idle");
      req0 = 1'b1;
      tick("early.grant0");
      tick("early.cnt1");
      req0  = 1'b0;
      req1  = 1'b1;
      data1 = 16'hBEEF;
      tick("early.handover");
      chk("early.disp_const", disp_data, 16'hBEEF);
      chk("early.hdone_const", {15'd0, hold_done}, 16'd0);
      req1 = 1'b0;
      tick("early.idle2");
      chk("early.idle_disp", disp_data, 16'h0000);

      // 5. async reset between edges while requester 1 owns
      req1 = 1'b1;
      tick("async.own1");
      tick("async.own1b");
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      check_all("async.mid");
      chk("async.gnt1_const", {15'd0, gnt1}, 16'd0);
      req0 = 1'b1;
      req1 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      tick("async.restart");
      chk("async.gnt0_const", {15'd0, gnt0}, 16'd1);

      // randomized contention with occasional async reset
      for (int i = 0; i < 600; i++) begin
         req0  = ($urandom_range(0, 3) != 0);
         req1  = ($urandom_range(0, 3) != 0);
         data0 = 16'($urandom);
         data1 = 16'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            m_reset();
            #1;
            check_all("rand.arst");
            @(negedge clk);
            rst_n = 1'b1;
         end
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
